// File: rtl/pwm_sched_pkg.sv
// Shared types and defaults for the PWM update scheduler.
package pwm_sched_pkg;

  // Default geometry; the top exposes these as overridable parameters.
  localparam int PWM_NCH = 4;
  localparam int PWM_DW  = 16;
  localparam int PWM_CW  = 8;
  localparam int CHW     = $clog2(PWM_NCH);

  // Shared config-port sequencer: waiting for an armed channel, or holding a load offer.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // One staged update at the default field width.
  typedef struct packed {
    logic [PWM_DW-1:0] duty;
    logic [PWM_DW-1:0] period;
  } staged_t;

  // (base + off) wrapped into 0..n-1, for off < n; works for non-power-of-two n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/pwm_update_scheduler_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module pwm_rr_arbiter
  import pwm_sched_pkg::*;
#(
  parameter int N = PWM_NCH
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] sel;

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      sel = IW'(wrap_add(int'(ptr), i, N));
      if (!valid && req[sel]) begin
        valid      = 1'b1;
        idx        = sel;
        grant[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_update_scheduler.sv
// Stages duty/period updates per channel, arms them at period boundaries (or
// immediately), and issues them round-robin onto the core's single load port.
module pwm_update_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int NCH = PWM_NCH,
  parameter int DW  = PWM_DW,
  parameter int CW  = PWM_CW
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   sched_en,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [$clog2(NCH)-1:0] cmd_chan,
  input  logic                   cmd_imm,
  input  logic [DW-1:0]          cmd_duty,
  input  logic [DW-1:0]          cmd_period,
  input  logic [NCH-1:0]         pwm_period_end,
  output logic                   load_valid,
  input  logic                   load_ready,
  output logic [$clog2(NCH)-1:0] load_chan,
  output logic [DW-1:0]          load_duty,
  output logic [DW-1:0]          load_period,
  output logic [NCH-1:0]         pending_o,
  output logic [CW-1:0]          coal_cnt,
  output logic                   irq_done
);

  localparam int CIW = $clog2(NCH);

  typedef struct packed {
    logic [DW-1:0] duty;
    logic [DW-1:0] period;
  } entry_t;

  entry_t         staged_q [NCH];
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] armed_q, armed_d;
  state_t         state_q, state_d;
  logic [CIW-1:0] ptr_q, ptr_d;
  logic           dirty_q, dirty_d;   // loaded channel got a newer update while its load was on offer
  logic           irq_arm_q;

  logic [NCH-1:0] grant_oh;
  logic [CIW-1:0] grant_idx;
  logic           grant_any;
  logic           grant;
  logic           handshake;
  logic           cmd_hits_load;
  logic           coalesce;
  logic [NCH-1:0] load_oh;

  // Updates coalesce into the staging registers, so the front-end is never stalled.
  assign cmd_ready = wb_rst_ni;
  assign pending_o = pending_q;

  assign handshake     = (state_q == ISSUE) && load_valid && load_ready;
  assign load_oh       = handshake ? (NCH'(1) << load_chan) : '0;
  assign cmd_hits_load = cmd_valid && (state_q == ISSUE) && (cmd_chan == load_chan);
  assign coalesce      = cmd_valid && pending_q[cmd_chan] && !(handshake && (cmd_chan == load_chan));

  pwm_rr_arbiter #(.N(NCH)) u_arb (
    .req   (armed_q),
    .ptr   (ptr_q),
    .grant (grant_oh),
    .idx   (grant_idx),
    .valid (grant_any)
  );

  // Sequencer next state: grant in IDLE, retire on handshake in ISSUE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dirty_d = dirty_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          grant   = 1'b1;
          state_d = ISSUE;
          dirty_d = cmd_valid && grant_oh[cmd_chan];
        end
      end
      ISSUE: begin
        if (handshake) begin
          state_d = IDLE;
          ptr_d   = CIW'(wrap_add(int'(load_chan), 1, NCH));
          dirty_d = 1'b0;
        end else if (cmd_hits_load) begin
          dirty_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending/armed bookkeeping; later statements take priority over earlier ones.
  always_comb begin
    pending_d = pending_q;
    armed_d   = armed_q;
    if (sched_en) armed_d = armed_d | (pending_q & pwm_period_end);
    // A newer staged value keeps the channel pending after the old one is loaded.
    if (handshake && !dirty_q) begin
      pending_d = pending_d & ~load_oh;
      armed_d   = armed_d & ~load_oh;
    end
    if (cmd_valid) begin
      pending_d[cmd_chan] = 1'b1;
      armed_d[cmd_chan]   = cmd_imm && sched_en;
    end
  end

  // Sequencer and flag registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      dirty_q   <= 1'b0;
      pending_q <= '0;
      armed_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      dirty_q   <= dirty_d;
      pending_q <= pending_d;
      armed_q   <= armed_d;
    end
  end

  // Staging registers capture the latest accepted value per channel.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      // NOTE: the staging array is reset because staged updates must be lost on reset, not replayed.
      for (int i = 0; i < NCH; i++) staged_q[i] <= '0;
    end else if (cmd_valid) begin
      staged_q[cmd_chan] <= '{duty: cmd_duty, period: cmd_period};
    end
  end

  // Load port: latched at grant, held until the core accepts.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      load_valid  <= 1'b0;
      load_chan   <= '0;
      load_duty   <= '0;
      load_period <= '0;
    end else if (grant) begin
      load_valid  <= 1'b1;
      load_chan   <= grant_idx;
      load_duty   <= staged_q[grant_idx].duty;
      load_period <= staged_q[grant_idx].period;
    end else if (handshake) begin
      load_valid  <= 1'b0;
    end
  end

  // Saturating count of updates that overwrote a still-pending one.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      coal_cnt <= '0;
    end else if (coalesce && (coal_cnt != '1)) begin
      coal_cnt <= coal_cnt + 1'b1;
    end
  end

  // Done interrupt: one cycle after a handshake empties the pending set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_arm_q <= 1'b0;
      irq_done  <= 1'b0;
    end else begin
      irq_arm_q <= handshake && (pending_d == '0);
      irq_done  <= irq_arm_q;
    end
  end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Scoreboard bench for pwm_update_scheduler: expected loads are queued as
// stimulus is driven and checked when the core-side handshake occurs.
module tb_pwm_update_scheduler;
  import pwm_sched_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CW  = 8;

  logic           wb_clk_i = 1'b0;
  logic           wb_rst_ni = 1'b0;
  logic           sched_en = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_chan = '0;
  logic           cmd_imm = 1'b0;
  logic [DW-1:0]  cmd_duty = '0;
  logic [DW-1:0]  cmd_period = '0;
  logic [NCH-1:0] pwm_period_end = '0;
  logic           load_valid;
  logic           load_ready = 1'b0;
  logic [1:0]     load_chan;
  logic [DW-1:0]  load_duty;
  logic [DW-1:0]  load_period;
  logic [NCH-1:0] pending_o;
  logic [CW-1:0]  coal_cnt;
  logic           irq_done;

  typedef struct {
    int      chan;
    staged_t val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  pwm_update_scheduler #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_ni      (wb_rst_ni),
    .sched_en       (sched_en),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_chan       (cmd_chan),
    .cmd_imm        (cmd_imm),
    .cmd_duty       (cmd_duty),
    .cmd_period     (cmd_period),
    .pwm_period_end (pwm_period_end),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_chan      (load_chan),
    .load_duty      (load_duty),
    .load_period    (load_period),
    .pending_o      (pending_o),
    .coal_cnt       (coal_cnt),
    .irq_done       (irq_done)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Scoreboard: every accepted load must match the oldest queued expectation.
  always @(negedge wb_clk_i) begin
    if (wb_rst_ni && load_valid && load_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got load chan %0d duty %h period %h, required no load",
                 load_chan, load_duty, load_period);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(load_chan) != mon_e.chan || load_duty !== mon_e.val.duty ||
            load_period !== mon_e.val.period) begin
          n_bad++;
          $display("FAIL sb_load: got chan %0d duty %h period %h, required chan %0d duty %h period %h",
                   load_chan, load_duty, load_period, mon_e.chan, mon_e.val.duty, mon_e.val.period);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic apply_reset();
    wb_rst_ni      = 1'b0;
    cmd_valid      = 1'b0;
    cmd_imm        = 1'b0;
    pwm_period_end = '0;
    load_ready     = 1'b0;
    sched_en       = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    wb_rst_ni = 1'b1;
    tick();
  endtask

  task automatic send_cmd(input int ch, input logic [DW-1:0] duty, input logic [DW-1:0] per,
                          input logic imm);
    cmd_valid  = 1'b1;
    cmd_chan   = 2'(ch);
    cmd_duty   = duty;
    cmd_period = per;
    cmd_imm    = imm;
    tick();
    cmd_valid = 1'b0;
    cmd_imm   = 1'b0;
  endtask

  task automatic pulse_pe(input logic [NCH-1:0] mask);
    pwm_period_end = mask;
    tick();
    pwm_period_end = '0;
  endtask

  task automatic expect_load(input int ch, input logic [DW-1:0] duty, input logic [DW-1:0] per);
    exp_t e;
    e.chan       = ch;
    e.val.duty   = duty;
    e.val.period = per;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d loads outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({load_valid, irq_done, cmd_ready} !== 3'b000 || pending_o !== 4'h0 || coal_cnt !== 8'h00 ||
        load_chan !== 2'd0 || load_duty !== 16'h0 || load_period !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid %b irq %b ready %b pend %b coal %0d, required all 0",
               load_valid, irq_done, cmd_ready, pending_o, coal_cnt);
    end
    wb_rst_ni = 1'b1;
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got cmd_ready %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_basic_arm();
    send_cmd(1, 16'h0040, 16'h0100, 1'b0);
    n_cmp++;
    if (pending_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL basic_pending: got %b, required 0010", pending_o);
    end
    repeat (3) tick();
    n_cmp++;
    if (load_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_no_early_load: got load_valid %b, required 0", load_valid);
    end
    pulse_pe(4'b0010);
    n_cmp++;
    if (load_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_latency1: got load_valid %b one edge after period end, required 0", load_valid);
    end
    expect_load(1, 16'h0040, 16'h0100);
    tick();
    n_cmp++;
    if (load_valid !== 1'b1 || load_chan !== 2'd1 || load_duty !== 16'h0040 || load_period !== 16'h0100) begin
      n_bad++;
      $display("FAIL basic_load: got valid %b chan %0d duty %h per %h, required 1 1 0040 0100",
               load_valid, load_chan, load_duty, load_period);
    end
    load_ready = 1'b1;
    drain("basic", 4);
    load_ready = 1'b0;
    n_cmp++;
    if (pending_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_retire: got pending %b, required 0000", pending_o);
    end
  endtask

  task automatic test_backpressure();
    repeat (3) tick();
    send_cmd(2, 16'h1234, 16'h5678, 1'b1);
    expect_load(2, 16'h1234, 16'h5678);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (load_valid !== 1'b1 || load_chan !== 2'd2 || load_duty !== 16'h1234 || load_period !== 16'h5678) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got valid %b chan %0d duty %h per %h, required 1 2 1234 5678",
                 i, load_valid, load_chan, load_duty, load_period);
      end
      tick();
    end
    load_ready = 1'b1;
    tick();
    load_ready = 1'b0;
    n_cmp++;
    if (pending_o !== 4'b0000 || irq_done !== 1'b0 || load_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_retire: got pend %b irq %b valid %b, required 0000 0 0", pending_o, irq_done, load_valid);
    end
    tick();
    n_cmp++;
    if (irq_done !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_pulse: got irq_done %b, required 1", irq_done);
    end
    tick();
    n_cmp++;
    if (irq_done !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_single: got irq_done %b on second cycle, required 0", irq_done);
    end
    drain("hold", 1);
  endtask

  task automatic test_round_robin();
    apply_reset();
    load_ready = 1'b1;
    send_cmd(0, 16'h0a00, 16'h0b00, 1'b0);
    send_cmd(1, 16'h0a01, 16'h0b01, 1'b0);
    send_cmd(3, 16'h0a03, 16'h0b03, 1'b0);
    expect_load(0, 16'h0a00, 16'h0b00);
    expect_load(1, 16'h0a01, 16'h0b01);
    expect_load(3, 16'h0a03, 16'h0b03);
    pulse_pe(4'b1011);
    drain("rr_first", 20);
    for (int c = 0; c < NCH; c++) begin
      send_cmd(c, 16'h0c00 + 16'(c), 16'h0d00 + 16'(c), 1'b0);
      expect_load(c, 16'h0c00 + 16'(c), 16'h0d00 + 16'(c));
    end
    pulse_pe(4'b1111);
    drain("rr_resume", 20);
    load_ready = 1'b0;
    n_cmp++;
    if (pending_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL rr_empty: got pending %b, required 0000", pending_o);
    end
  endtask

  task automatic test_coalesce();
    apply_reset();
    send_cmd(2, 16'h0001, 16'h0080, 1'b0);
    send_cmd(2, 16'h0002, 16'h0080, 1'b0);
    send_cmd(2, 16'h0003, 16'h0080, 1'b0);
    n_cmp++;
    if (coal_cnt !== 8'd2 || pending_o !== 4'b0100) begin
      n_bad++;
      $display("FAIL coal_three: got coal %0d pend %b, required 2 0100", coal_cnt, pending_o);
    end
    load_ready = 1'b1;
    expect_load(2, 16'h0003, 16'h0080);
    pulse_pe(4'b0100);
    drain("coal_single", 6);
    repeat (2) tick();
    load_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_chan  = 2'd0;
    cmd_imm   = 1'b0;
    for (int i = 0; i < 301; i++) begin
      cmd_duty = 16'(i);
      tick();
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (coal_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL coal_saturate: got coal %0d, required 255", coal_cnt);
    end
  endtask

  task automatic test_sched_disable();
    apply_reset();
    sched_en = 1'b0;
    send_cmd(0, 16'h0777, 16'h0888, 1'b1);
    pulse_pe(4'b0001);
    repeat (4) tick();
    n_cmp++;
    if (load_valid !== 1'b0 || pending_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL disable_hold: got valid %b pend %b, required 0 0001", load_valid, pending_o);
    end
    sched_en = 1'b1;
    expect_load(0, 16'h0777, 16'h0888);
    pulse_pe(4'b0001);
    tick();
    n_cmp++;
    if (load_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL disable_release: got load_valid %b, required 1", load_valid);
    end
    load_ready = 1'b1;
    drain("disable", 4);
    load_ready = 1'b0;
  endtask

  task automatic test_issue_overwrite();
    apply_reset();
    send_cmd(1, 16'h00a1, 16'h0200, 1'b1);
    expect_load(1, 16'h00a1, 16'h0200);
    tick();
    send_cmd(1, 16'h00b2, 16'h0300, 1'b0);
    n_cmp++;
    if (coal_cnt !== 8'd1 || load_duty !== 16'h00a1 || load_period !== 16'h0200) begin
      n_bad++;
      $display("FAIL ovw_issue: got coal %0d duty %h per %h, required 1 00a1 0200", coal_cnt, load_duty, load_period);
    end
    load_ready = 1'b1;
    tick();
    load_ready = 1'b0;
    n_cmp++;
    if (pending_o !== 4'b0010 || load_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovw_keep_pending: got pend %b valid %b, required 0010 0", pending_o, load_valid);
    end
    expect_load(1, 16'h00b2, 16'h0300);
    pulse_pe(4'b0010);
    load_ready = 1'b1;
    drain("ovw", 6);
    load_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    send_cmd(1, 16'h0011, 16'h0022, 1'b1);
    send_cmd(1, 16'h0033, 16'h0044, 1'b1);
    tick();
    n_cmp++;
    if (load_valid !== 1'b1 || coal_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL midrst_pre: got valid %b coal %0d, required 1 1", load_valid, coal_cnt);
    end
    #2;
    wb_rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (load_valid !== 1'b0 || pending_o !== 4'b0000 || coal_cnt !== 8'd0 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_async: got valid %b pend %b coal %0d ready %b, required 0 0000 0 0",
               load_valid, pending_o, coal_cnt, cmd_ready);
    end
    tick();
    wb_rst_ni = 1'b1;
    tick();
    load_ready = 1'b1;
    send_cmd(3, 16'h0055, 16'h0066, 1'b1);
    expect_load(3, 16'h0055, 16'h0066);
    drain("midrst_post", 6);
    load_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_arm();
    test_backpressure();
    test_round_robin();
    test_coalesce();
    test_sched_disable();
    test_issue_overwrite();
    test_mid_reset();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
